// File: rtl/simon_rr_scheduler.sv
// simon_rr_scheduler: round-robin front end that shares a single Simon
// encryption core between NREQ requesters. It arbitrates, latches the
// winning operands, pulses core_en once, detects the rising edge of
// core_done and returns the ciphertext to the winning requester.
// Optional feature: define SIMON_SCHED_TIMEOUT_EN to add a WAIT-state
// watchdog that answers with rsp_err=1 and rsp_ct=0 after TMO cycles.
module simon_rr_scheduler #(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int NREQ = 2,
    parameter int TMO  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*2*N-1:0]   req_pt,
    input  logic [NREQ*N*M-1:0]   req_key,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [2*N-1:0]        rsp_ct,
    output logic                  rsp_err,
    output logic                  core_en,
    output logic [2*N-1:0]        core_pt,
    output logic [N*M-1:0]        core_key,
    input  logic [2*N-1:0]        core_ct,
    input  logic                  core_done,
    output logic                  busy
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] gp;
    logic [IW-1:0] id;
    logic [IW-1:0] winner;
    logic [IW-1:0] sel;
    int            idx;
    logic          found;
    logic          accept;
    logic          done_q;
    logic          completion;
    logic          handshake;
    logic          timeout;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(gp) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IW'(idx);
            if (!found && req_valid[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    assign accept     = (state == IDLE) && found && rst;
    assign req_ready  = accept ? (NREQ'(1) << winner) : '0;
    assign rsp_valid  = (state == RESP) ? (NREQ'(1) << id) : '0;
    assign core_en    = (state == ISSUE);
    assign busy       = (state != IDLE);
    assign completion = !done_q && core_done;
    assign handshake  = (state == RESP) && rsp_ready[id];

`ifdef SIMON_SCHED_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign timeout = (state == WAIT) && !completion && (tmo_cnt == 8'(TMO - 1));

    // Watchdog counter: restarts while issuing, counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Error flag set by a watchdog expiry and held until the response is taken
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_err <= 1'b0;
        end else if (timeout) begin
            rsp_err <= 1'b1;
        end else if (handshake) begin
            rsp_err <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register; reset drops any job in flight without a response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the accept/issue/wait/respond sequence
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (completion || timeout) state_nxt = RESP;
            RESP:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, grant bookkeeping, done edge history and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            gp       <= IW'(NREQ - 1);
            id       <= '0;
            core_pt  <= '0;
            core_key <= '0;
            rsp_ct   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= core_done;
            if (accept) begin
                core_pt  <= req_pt[int'(winner)*2*N +: 2*N];
                core_key <= req_key[int'(winner)*N*M +: N*M];
                id       <= winner;
                gp       <= winner;
            end
            if ((state == WAIT) && completion) begin
                rsp_ct <= core_ct;
            end else if (timeout) begin
                rsp_ct <= '0;
            end
        end
    end

endmodule

// File: tb/tb_simon_rr_scheduler.sv
// tb_simon_rr_scheduler: directed and randomized checks of the round-robin
// Simon scheduler. The bench plays the Simon core itself, computing real
// Simon32/64 ciphertexts, and predicts grants with a simple rotating model.
module tb_simon_rr_scheduler;

    localparam int N    = 16;
    localparam int M    = 4;
    localparam int NREQ = 2;
    localparam int TMO  = 20;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*2*N-1:0] req_pt;
    logic [NREQ*N*M-1:0] req_key;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [2*N-1:0]      rsp_ct;
    logic                rsp_err;
    logic                core_en;
    logic [2*N-1:0]      core_pt;
    logic [N*M-1:0]      core_key;
    logic [2*N-1:0]      core_ct = '0;
    logic                core_done = 1'b0;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int last;
    int core_lat = 3;
    int stale_cycles = 0;
    bit stuck = 1'b0;

    always #5 clk = ~clk;

    simon_rr_scheduler #(.N(N), .M(M), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_pt    (req_pt),
        .req_key   (req_key),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ct    (rsp_ct),
        .rsp_err   (rsp_err),
        .core_en   (core_en),
        .core_pt   (core_pt),
        .core_key  (core_key),
        .core_ct   (core_ct),
        .core_done (core_done),
        .busy      (busy)
    );

    // Reference Simon32/64 encryption
    function automatic logic [31:0] simon32(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k [32];
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] tmp;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
            tmp  = tmp ^ {tmp[0], tmp[15:1]};
            k[i] = ~k[i-4] ^ tmp ^ {15'd0, z[61]} ^ 16'd3;
            z    = z << 1;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        return NREQ'(1) << w;
    endfunction

    // Grant model: first valid requester after the previous winner, wrapping
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int prev);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(prev + k) % NREQ]) return (prev + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural Simon core: done drops (optionally after a stale delay), then rises with the result
    logic [31:0] job_pt;
    logic [63:0] job_key;
    bit          active = 1'b0;
    int          ctr = 0;
    int          t_low = 0;
    int          t_high = 0;
    always @(posedge clk) begin
        if (core_en) begin
            job_pt  <= core_pt;
            job_key <= core_key;
            active  <= 1'b1;
            ctr     <= 0;
            t_low   <= stale_cycles;
            t_high  <= stale_cycles + core_lat;
            if (stale_cycles == 0) begin
                core_done <= 1'b0;
                core_ct   <= $urandom;
            end
        end else if (active) begin
            ctr <= ctr + 1;
            if (ctr + 1 == t_low) begin
                core_done <= 1'b0;
                core_ct   <= $urandom;
            end
            if (ctr + 1 == t_high && !stuck) begin
                core_done <= 1'b1;
                core_ct   <= simon32(job_pt, job_key);
                active    <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        last = NREQ - 1;
    endtask

    task automatic randomizeOperands();
        req_pt  = {$urandom, $urandom};
        req_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One complete job from the current req_valid, checking every phase against the model
    task automatic applyStimulus(input int lat, input int stale, input int bp,
                                 output logic [NREQ-1:0] grant, output logic [31:0] ct);
        logic [31:0] exp_pt;
        logic [63:0] exp_key;
        logic [31:0] exp_ct;
        int          w;
        int          n;
        core_lat     = lat;
        stale_cycles = stale;
        grant        = '0;
        ct           = '0;
        #1;
        w = rr_pick(req_valid, last);
        if (w < 0) begin
            checkOutput("idle_req_ready", 64'(req_ready), 64'(0));
            checkOutput("idle_busy", 64'(busy), 64'(0));
            @(negedge clk);
            return;
        end
        grant = req_ready;
        checkOutput("req_ready", 64'(req_ready), 64'(onehot(w)));
        checkOutput("busy_at_accept", 64'(busy), 64'(0));
        exp_pt  = req_pt[w*32 +: 32];
        exp_key = req_key[w*64 +: 64];
        exp_ct  = simon32(exp_pt, exp_key);
        last    = w;
        @(negedge clk);
        checkOutput("core_en_issue", 64'(core_en), 64'(1));
        checkOutput("busy_issue", 64'(busy), 64'(1));
        checkOutput("core_pt", 64'(core_pt), 64'(exp_pt));
        checkOutput("core_key", 64'(core_key), 64'(exp_key));
        randomizeOperands();
        n = 0;
        while (rsp_valid == '0 && n < lat + stale + 40) begin
            @(negedge clk);
            n++;
            if (rsp_valid == '0) begin
                checkOutput("core_en_wait", 64'(core_en), 64'(0));
                checkOutput("core_pt_hold", 64'(core_pt), 64'(exp_pt));
                checkOutput("req_ready_wait", 64'(req_ready), 64'(0));
            end
        end
        checkOutput("rsp_latency", 64'(n), 64'(lat + stale + 2));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(onehot(w)));
        checkOutput("rsp_ct", 64'(rsp_ct), 64'(exp_ct));
        checkOutput("rsp_err", 64'(rsp_err), 64'(0));
        ct = rsp_ct;
        rsp_ready = ~onehot(w);
        repeat (bp) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'(onehot(w)));
            checkOutput("bp_rsp_ct", 64'(rsp_ct), 64'(exp_ct));
            checkOutput("bp_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = onehot(w);
        @(negedge clk);
        rsp_ready = '0;
        checkOutput("rsp_valid_cleared", 64'(rsp_valid), 64'(0));
        checkOutput("busy_after_rsp", 64'(busy), 64'(0));
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [NREQ-1:0] g;
        logic [31:0]     ct;
        int              n;
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_pt    = '0;
        req_key   = '0;
        last      = NREQ - 1;

        applyReset(3);
        rst = 1'b0;
        checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_rsp_ct", 64'(rsp_ct), 64'(0));
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'(0));
        checkOutput("rst_core_en", 64'(core_en), 64'(0));
        checkOutput("rst_core_pt", 64'(core_pt), 64'(0));
        checkOutput("rst_core_key", 64'(core_key), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_rst_busy", 64'(busy), 64'(0));
        checkOutput("post_rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);

        $display("[TB] single job with the reference vector");
        req_pt    = {32'h0, 32'h65656877};
        req_key   = {64'h0, 64'h1918111009080100};
        req_valid = 2'b01;
        applyStimulus(3, 0, 0, g, ct);
        req_valid = '0;
        checkOutput("known_vector_ct", 64'(ct), 64'(32'hc69be9bb));

        $display("[TB] contention with both requesters valid");
        applyReset(2);
        randomizeOperands();
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(int'($urandom_range(1, 5)), 0, 0, g, ct);
            checkOutput("contention_grant", 64'(g), 64'(onehot(j % 2)));
        end
        req_valid = '0;

        $display("[TB] response backpressure");
        randomizeOperands();
        req_valid = 2'b10;
        applyStimulus(2, 0, 10, g, ct);
        req_valid = '0;

        $display("[TB] stale core_done level");
        randomizeOperands();
        req_valid = 2'b01;
        applyStimulus(3, 4, 0, g, ct);
        req_valid = '0;

        $display("[TB] reset during WAIT");
        randomizeOperands();
        core_lat     = 6;
        stale_cycles = 0;
        req_valid    = 2'b01;
        #1;
        checkOutput("midrst_req_ready", 64'(req_ready), 64'(onehot(rr_pick(req_valid, last))));
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        applyReset(1);
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_core_pt", 64'(core_pt), 64'(0));
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checkOutput("midrst_no_rsp", 64'(rsp_valid), 64'(0));
            checkOutput("midrst_idle", 64'(busy), 64'(0));
        end
        randomizeOperands();
        req_valid = 2'b10;
        applyStimulus(2, 0, 1, g, ct);
        req_valid = '0;

`ifdef SIMON_SCHED_TIMEOUT_EN
        $display("[TB] watchdog with a stuck core");
        stuck        = 1'b1;
        core_lat     = 3;
        stale_cycles = 0;
        randomizeOperands();
        req_valid = 2'b01;
        #1;
        checkOutput("tmo_req_ready", 64'(req_ready), 64'(onehot(rr_pick(req_valid, last))));
        last = rr_pick(req_valid, last);
        @(negedge clk);
        req_valid = '0;
        checkOutput("tmo_core_en", 64'(core_en), 64'(1));
        n = 0;
        while (rsp_valid == '0 && n < 4 * TMO) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo_latency", 64'(n), 64'(TMO + 1));
        checkOutput("tmo_rsp_valid", 64'(rsp_valid), 64'(onehot(last)));
        checkOutput("tmo_rsp_err", 64'(rsp_err), 64'(1));
        checkOutput("tmo_rsp_ct", 64'(rsp_ct), 64'(0));
        rsp_ready = onehot(last);
        @(negedge clk);
        rsp_ready = '0;
        checkOutput("tmo_err_cleared", 64'(rsp_err), 64'(0));
        checkOutput("tmo_idle", 64'(busy), 64'(0));
        stuck = 1'b0;
`endif

        $display("[TB] randomized traffic");
        for (int j = 0; j < 24; j++) begin
            randomizeOperands();
            req_valid = NREQ'($urandom_range(0, 3));
            applyStimulus(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), g, ct);
        end
        req_valid = '0;
        n = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
